regfile_wb_scheduler: RTL and testbench



---
 rtl/riscv_pkg.sv | 15 +
 rtl/wb_fifo.sv | 57 +++++
 rtl/regfile_wb_scheduler.sv | 120 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-datapath definitions: data width, register index width,
// register count and the writeback request payload.
package riscv_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    // One register-file write: destination index plus data.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests with full/empty flags.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   i_push, i_din   write strobe and payload (ignored when full)
//   i_pop           read strobe (ignored when empty)
//   o_dout          head entry, valid while o_empty=0
//   o_full, o_empty occupancy flags
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_push,
    input  wb_req_t i_din,
    input  logic    i_pop,
    output wb_req_t o_dout,
    output logic    o_full,
    output logic    o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    wb_req_t       r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset; empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler and scoreboard for the 32x64 integer register file.
// Arbitrates the single write port between the ALU (absolute priority) and a
// load-return queue, and tracks pending destinations to gate issue.
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   iss_valid/rs1/rs2/rd, iss_ready issue handshake (iss_ready combinational)
//   alu_valid/rd/data               ALU writeback, no backpressure
//   ld_valid/rd/data, ld_ready      load return into the queue
//   rf_wr_en/idx/data               registered register-file write port
//   busy                            pending-write scoreboard, bit 0 always 0
module regfile_wb_scheduler
    import riscv_pkg::*;
#(
    parameter int unsigned LD_Q_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iss_valid,
    input  logic [REG_IDX_W-1:0] iss_rs1,
    input  logic [REG_IDX_W-1:0] iss_rs2,
    input  logic [REG_IDX_W-1:0] iss_rd,
    output logic                 iss_ready,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [REG_IDX_W-1:0] ld_rd,
    input  logic [XLEN-1:0]      ld_data,
    output logic                 rf_wr_en,
    output logic [REG_IDX_W-1:0] rf_wr_idx,
    output logic [XLEN-1:0]      rf_wr_data,
    output logic [NUM_REGS-1:0]  busy
);

    logic                 r_wr_en;
    logic [REG_IDX_W-1:0] r_wr_idx;
    logic [XLEN-1:0]      r_wr_data;
    logic [NUM_REGS-1:0]  r_busy;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    wb_req_t              w_ld_head;
    wb_req_t              w_ld_in;
    logic                 w_ld_push;
    logic                 w_ld_pop;
    logic                 w_sel_valid;
    wb_req_t              w_sel;
    logic                 w_iss_fire;
    logic [NUM_REGS-1:0]  w_busy_nxt;

    assign w_ld_in.rd   = ld_rd;
    assign w_ld_in.data = ld_data;

    assign ld_ready  = reset & ~w_fifo_full;
    assign w_ld_push = ld_valid & ld_ready;
    // Queue drains only in cycles the ALU leaves the port free.
    assign w_ld_pop  = ~alu_valid & ~w_fifo_empty;

    wb_fifo #(
        .DEPTH (LD_Q_DEPTH)
    ) u_ld_q (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_ld_push),
        .i_din   (w_ld_in),
        .i_pop   (w_ld_pop),
        .o_dout  (w_ld_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign iss_ready  = reset & ~r_busy[iss_rs1] & ~r_busy[iss_rs2] & ~r_busy[iss_rd];
    assign w_iss_fire = iss_valid & iss_ready;

    // Write-port arbitration: ALU first, then queue head.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = '0;
        if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel.rd    = alu_rd;
            w_sel.data  = alu_data;
        end else if (!w_fifo_empty) begin
            w_sel_valid = 1'b1;
            w_sel       = w_ld_head;
        end
    end

    // Scoreboard next state: clear on commit, then set on issue so set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wr_en) w_busy_nxt[r_wr_idx] = 1'b0;
        if (w_iss_fire) w_busy_nxt[iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Register stage and scoreboard state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_wr_en <= w_sel_valid && (w_sel.rd != '0);
            if (w_sel_valid) begin
                r_wr_idx  <= w_sel.rd;
                r_wr_data <= w_sel.data;
            end
        end
    end

    assign rf_wr_en   = r_wr_en;
    assign rf_wr_idx  = r_wr_idx;
    assign rf_wr_data = r_wr_data;
    assign busy       = r_busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: a table of issue-gating
// vectors, a write-port scoreboard fed in expected commit order, and
// hand-written sequences for the multi-cycle cases.
module tb_regfile_wb_scheduler;
    import riscv_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 iss_valid;
    logic [REG_IDX_W-1:0] iss_rs1, iss_rs2, iss_rd;
    logic                 iss_ready;
    logic                 alu_valid;
    logic [REG_IDX_W-1:0] alu_rd;
    logic [XLEN-1:0]      alu_data;
    logic                 ld_valid;
    logic                 ld_ready;
    logic [REG_IDX_W-1:0] ld_rd;
    logic [XLEN-1:0]      ld_data;
    logic                 rf_wr_en;
    logic [REG_IDX_W-1:0] rf_wr_idx;
    logic [XLEN-1:0]      rf_wr_data;
    logic [NUM_REGS-1:0]  busy;

    int n_tests = 0;
    int n_fail  = 0;

    wb_req_t         exp_q[$];
    logic [XLEN-1:0] tb_rf [NUM_REGS];

    typedef struct {
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic                 exp_ready;
    } iss_vec_t;

    iss_vec_t vecs[8];

    regfile_wb_scheduler #(
        .LD_Q_DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iss_valid  (iss_valid),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_rd     (iss_rd),
        .iss_ready  (iss_ready),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_idx  (rf_wr_idx),
        .rf_wr_data (rf_wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic expect_wr(input logic [REG_IDX_W-1:0] rd, input logic [XLEN-1:0] data);
        wb_req_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Register file model: latches each committed write.
    always @(posedge clk) begin
        if (rf_wr_en === 1'b1) tb_rf[rf_wr_idx] <= rf_wr_data;
    end

    // Scoreboard: every write on the port must match the next expected one.
    always @(negedge clk) begin
        if (rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got write idx=%0d data=0x%0h, required no write",
                         rf_wr_idx, rf_wr_data);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                chk("sb_wr_idx", 64'(rf_wr_idx), 64'(e.rd));
                chk("sb_wr_data", rf_wr_data, e.data);
            end
        end
    end

    initial begin
        int  ld_i;
        logic acc;

        vecs[0] = '{rs1: 5'd0,  rs2: 5'd0,  rd: 5'd0,  exp_ready: 1'b1};
        vecs[1] = '{rs1: 5'd5,  rs2: 5'd0,  rd: 5'd0,  exp_ready: 1'b0};
        vecs[2] = '{rs1: 5'd0,  rs2: 5'd9,  rd: 5'd0,  exp_ready: 1'b0};
        vecs[3] = '{rs1: 5'd0,  rs2: 5'd0,  rd: 5'd5,  exp_ready: 1'b0};
        vecs[4] = '{rs1: 5'd1,  rs2: 5'd2,  rd: 5'd3,  exp_ready: 1'b1};
        vecs[5] = '{rs1: 5'd9,  rs2: 5'd5,  rd: 5'd31, exp_ready: 1'b0};
        vecs[6] = '{rs1: 5'd4,  rs2: 5'd6,  rd: 5'd10, exp_ready: 1'b1};
        vecs[7] = '{rs1: 5'd31, rs2: 5'd30, rd: 5'd29, exp_ready: 1'b1};

        // Reset held three cycles with random inputs.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iss_valid = 1'($urandom_range(0, 1));
            iss_rs1   = 5'($urandom);
            iss_rs2   = 5'($urandom);
            iss_rd    = 5'($urandom);
            alu_valid = 1'($urandom_range(0, 1));
            alu_rd    = 5'($urandom);
            alu_data  = {32'($urandom), 32'($urandom)};
            ld_valid  = 1'($urandom_range(0, 1));
            ld_rd     = 5'($urandom);
            ld_data   = {32'($urandom), 32'($urandom)};
            #1;
            chk("rst_ld_ready", 64'(ld_ready), 64'd0);
            chk("rst_iss_ready", 64'(iss_ready), 64'd0);
            cyc();
        end
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_en", 64'(rf_wr_en), 64'd0);
        idle();
        iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
        alu_rd = '0; ld_rd = '0; alu_data = '0; ld_data = '0;
        reset = 1'b1;
        #1;
        chk("rel_ld_ready", 64'(ld_ready), 64'd1);
        chk("rel_iss_ready", 64'(iss_ready), 64'd1);
        cyc();

        // RAW stall on x5.
        iss_valid = 1'b1; iss_rd = 5'd5;
        #1;
        chk("raw_issue_ready", 64'(iss_ready), 64'd1);
        cyc();
        iss_rs1 = 5'd5; iss_rd = 5'd6;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD;
        expect_wr(5'd5, 64'hDEAD);
        #1;
        chk("raw_stall", 64'(iss_ready), 64'd0);
        chk("raw_busy", 64'(busy), 64'h20);
        cyc();
        alu_valid = 1'b0;
        chk("raw_wr_en", 64'(rf_wr_en), 64'd1);
        chk("raw_wr_idx", 64'(rf_wr_idx), 64'd5);
        chk("raw_still_stall", 64'(iss_ready), 64'd0);
        cyc();
        chk("raw_release", 64'(iss_ready), 64'd1);
        chk("raw_rf_x5", tb_rf[5], 64'hDEAD);
        iss_valid = 1'b0; iss_rs1 = '0; iss_rd = '0;
        cyc();

        // Port conflict: ALU x3 and load x4 in the same cycle.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h3333;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 64'h4444;
        expect_wr(5'd3, 64'h3333);
        expect_wr(5'd4, 64'h4444);
        #1;
        chk("pc_ld_ready", 64'(ld_ready), 64'd1);
        cyc();
        idle();
        chk("pc_n1_en", 64'(rf_wr_en), 64'd1);
        chk("pc_n1_idx", 64'(rf_wr_idx), 64'd3);
        cyc();
        chk("pc_n2_en", 64'(rf_wr_en), 64'd1);
        chk("pc_n2_idx", 64'(rf_wr_idx), 64'd4);
        cyc();
        chk("pc_n3_idle", 64'(rf_wr_en), 64'd0);

        // Queue full under continuous ALU traffic, then FIFO-order drain.
        ld_i = 0;
        for (int c = 0; c < 8; c++) begin
            alu_valid = (c < 4);
            alu_rd    = 5'(10 + c);
            alu_data  = 64'hA000 + 64'(c);
            if (c < 4) expect_wr(5'(10 + c), 64'hA000 + 64'(c));
            if (c == 4) begin
                for (int k = 0; k < 3; k++) expect_wr(5'(20 + k), 64'hB000 + 64'(k));
            end
            ld_valid = (ld_i < 3);
            ld_rd    = 5'(20 + ld_i);
            ld_data  = 64'hB000 + 64'(ld_i);
            #1;
            if (c < 2) chk("qf_ready_open", 64'(ld_ready), 64'd1);
            if (c == 2 || c == 3 || c == 4) chk("qf_ready_full", 64'(ld_ready), 64'd0);
            if (c >= 1 && c <= 4) chk("qf_alu_idx", 64'(rf_wr_idx), 64'(10 + c - 1));
            if (c >= 5) begin
                chk("qf_ld_en", 64'(rf_wr_en), 64'd1);
                chk("qf_ld_idx", 64'(rf_wr_idx), 64'(20 + c - 5));
            end
            acc = ld_valid & ld_ready;
            cyc();
            if (acc) ld_i++;
        end
        idle();
        chk("qf_all_pushed", 64'(ld_i), 64'd3);
        chk("qf_drained", 64'(rf_wr_en), 64'd0);

        // x0 handling.
        iss_valid = 1'b1; iss_rd = 5'd0;
        cyc();
        iss_valid = 1'b0;
        chk("x0_issue_busy", 64'(busy), 64'd0);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hBAD0;
        cyc();
        alu_valid = 1'b0;
        chk("x0_alu_no_wr", 64'(rf_wr_en), 64'd0);
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 64'hBAD1;
        cyc();
        ld_valid = 1'b0;
        chk("x0_ld_pop_cycle", 64'(rf_wr_en), 64'd0);
        cyc();
        chk("x0_ld_no_wr", 64'(rf_wr_en), 64'd0);
        alu_valid = 1'b1; alu_rd = 5'd0;
        ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 64'h8888;
        cyc();
        ld_valid = 1'b0;
        chk("x0_ld_was_popped", 64'(ld_ready), 64'd1);
        chk("x0_alu_hold_no_wr", 64'(rf_wr_en), 64'd0);
        cyc();
        alu_valid = 1'b0;
        expect_wr(5'd8, 64'h8888);
        cyc();
        chk("x0_x8_en", 64'(rf_wr_en), 64'd1);
        cyc();

        // Table-driven issue gating with x5 and x9 reserved.
        iss_valid = 1'b1; iss_rs1 = '0; iss_rs2 = '0; iss_rd = 5'd5;
        cyc();
        iss_rd = 5'd9;
        cyc();
        iss_valid = 1'b0;
        chk("tbl_busy", 64'(busy), 64'h220);
        for (int v = 0; v < 8; v++) begin
            iss_rs1 = vecs[v].rs1;
            iss_rs2 = vecs[v].rs2;
            iss_rd  = vecs[v].rd;
            #1;
            chk($sformatf("tbl_ready_%0d", v), 64'(iss_ready), 64'(vecs[v].exp_ready));
            cyc();
        end
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h5555;
        expect_wr(5'd5, 64'h5555);
        cyc();
        alu_rd = 5'd9; alu_data = 64'h9999;
        expect_wr(5'd9, 64'h9999);
        cyc();
        idle();
        cyc();
        cyc();
        chk("tbl_busy_clear", 64'(busy), 64'd0);

        // Reset mid-flight with two queued loads and x7 reserved.
        alu_valid = 1'b1; alu_rd = 5'd0;
        ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 64'h1111;
        iss_valid = 1'b1; iss_rs1 = '0; iss_rs2 = '0; iss_rd = 5'd7;
        #1;
        chk("rmf_issue_ready", 64'(iss_ready), 64'd1);
        cyc();
        iss_valid = 1'b0;
        ld_rd = 5'd12; ld_data = 64'h1212;
        chk("rmf_busy7", 64'(busy), 64'h80);
        chk("rmf_ld_ready", 64'(ld_ready), 64'd1);
        cyc();
        chk("rmf_full", 64'(ld_ready), 64'd0);
        idle();
        reset = 1'b0;
        cyc();
        chk("rmf_wr_en", 64'(rf_wr_en), 64'd0);
        chk("rmf_busy", 64'(busy), 64'd0);
        chk("rmf_ld_ready_rst", 64'(ld_ready), 64'd0);
        chk("rmf_iss_ready_rst", 64'(iss_ready), 64'd0);
        cyc();
        reset = 1'b1;
        #1;
        chk("rmf_rel_ld_ready", 64'(ld_ready), 64'd1);
        chk("rmf_rel_iss7", 64'(iss_ready), 64'd1);
        cyc();
        chk("rmf_no_wr", 64'(rf_wr_en), 64'd0);
        cyc();
        cyc();
        cyc();

        chk("sb_all_consumed", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
